// File: rtl/grf_scoreboard.sv
// -----------------------------------------------------------------------------
// grf_scoreboard
//   Pending-write scoreboard for the 32 general registers. It sits beside
//   decode and decides, in the same cycle, whether the decode instruction may
//   issue. It watches the GRF writeback port to retire pending writes.
//
//   Each register r in 1..31 has a saturating-free counter cnt[r] holding the
//   number of in-flight writes to r. The counter never wraps: a write to a full
//   destination is stalled instead. x0 is never tracked.
//
// Ports
//   i_Clk          clock, all state on rising edge
//   i_Rst          synchronous reset, active-high
//   i_Valid_1      decode holds a valid instruction
//   i_RS1Addr_5    rs1 index          i_RS1Used_1   instruction reads rs1
//   i_RS2Addr_5    rs2 index          i_RS2Used_1   instruction reads rs2
//   i_RDAddr_5     rd index           i_RDWrite_1   instruction writes rd
//   i_WBValid_1    GRF writeback this cycle
//   i_WBAddr_5     writeback register index
//   i_Flush_1      kill all younger in-flight instructions
//   o_Issue_1      instruction issues this cycle (combinational)
//   o_Stall_1      valid instruction held at decode (combinational)
//   o_Busy_32      registered per-register "write pending" view
//   o_Err_1        sticky: writeback seen for a register with nothing pending
// -----------------------------------------------------------------------------
module grf_scoreboard #(
   parameter int CNT_W     = 2,
   parameter int WB_BYPASS = 1
) (
   input  logic        i_Clk,
   input  logic        i_Rst,
   input  logic        i_Valid_1,
   input  logic [4:0]  i_RS1Addr_5,
   input  logic        i_RS1Used_1,
   input  logic [4:0]  i_RS2Addr_5,
   input  logic        i_RS2Used_1,
   input  logic [4:0]  i_RDAddr_5,
   input  logic        i_RDWrite_1,
   input  logic        i_WBValid_1,
   input  logic [4:0]  i_WBAddr_5,
   input  logic        i_Flush_1,
   output logic        o_Issue_1,
   output logic        o_Stall_1,
   output logic [31:0] o_Busy_32,
   output logic        o_Err_1
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic             BYPASS  = (WB_BYPASS != 0);

   logic [CNT_W-1:0] cnt_q [32];
   logic [CNT_W-1:0] cnt_d [32];
   logic [31:0]      busy_q, busy_d;
   logic             err_q, err_set_d;

   logic [CNT_W-1:0] rs1_cnt, rs2_cnt, rd_cnt;
   logic             rs1_retire, rs2_retire, rd_retire;
   logic             rs1_haz, rs2_haz, rd_full;
   logic             live;
   logic             stall_c, issue_c;

   // ---------------------------------------------------------------------------
   // Issue decision (zero-cycle latency)
   // ---------------------------------------------------------------------------
   always_comb begin
      rs1_cnt    = (i_RS1Addr_5 != 5'd0) ? cnt_q[i_RS1Addr_5] : '0;
      rs2_cnt    = (i_RS2Addr_5 != 5'd0) ? cnt_q[i_RS2Addr_5] : '0;
      rd_cnt     = (i_RDAddr_5  != 5'd0) ? cnt_q[i_RDAddr_5]  : '0;

      rs1_retire = i_WBValid_1 && (i_WBAddr_5 == i_RS1Addr_5) && (i_RS1Addr_5 != 5'd0);
      rs2_retire = i_WBValid_1 && (i_WBAddr_5 == i_RS2Addr_5) && (i_RS2Addr_5 != 5'd0);
      rd_retire  = i_WBValid_1 && (i_WBAddr_5 == i_RDAddr_5)  && (i_RDAddr_5  != 5'd0);

      // A source whose last pending write retires this very cycle can be read
      // straight off the writeback path when bypass is enabled.
      rs1_haz = i_RS1Used_1 && (i_RS1Addr_5 != 5'd0) && (rs1_cnt != '0) &&
                !(BYPASS && (rs1_cnt == CNT_ONE) && rs1_retire);
      rs2_haz = i_RS2Used_1 && (i_RS2Addr_5 != 5'd0) && (rs2_cnt != '0) &&
                !(BYPASS && (rs2_cnt == CNT_ONE) && rs2_retire);

      // A full destination counter may still accept a write if one retires in
      // the same cycle: the increment and decrement cancel.
      rd_full = i_RDWrite_1 && (i_RDAddr_5 != 5'd0) && (rd_cnt == CNT_MAX) && !rd_retire;

      // Reset and flush both silence the decode handshake.
      live    = !i_Rst && i_Valid_1 && !i_Flush_1;
      stall_c = live && (rs1_haz || rs2_haz || rd_full);
      issue_c = live && !stall_c;
   end

   // ---------------------------------------------------------------------------
   // Counter next state
   // ---------------------------------------------------------------------------
   always_comb begin
      logic inc, dec;
      err_set_d = 1'b0;
      busy_d    = '0;
      cnt_d[0]  = '0;
      for (int r = 1; r < 32; r++) begin
         inc      = issue_c && i_RDWrite_1 && (i_RDAddr_5 == 5'(r));
         dec      = i_WBValid_1 && (i_WBAddr_5 == 5'(r));
         cnt_d[r] = cnt_q[r];
         if (i_Flush_1) begin
            // Flush drops every pending write; the writeback of this cycle
            // belongs to a killed instruction and is ignored entirely.
            cnt_d[r] = '0;
         end else if (inc && !dec) begin
            cnt_d[r] = cnt_q[r] + CNT_ONE;
         end else if (dec && !inc) begin
            if (cnt_q[r] != '0) begin
               cnt_d[r] = cnt_q[r] - CNT_ONE;
            end else begin
               err_set_d = 1'b1;
            end
         end
         busy_d[r] = (cnt_d[r] != '0);
      end
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         for (int r = 0; r < 32; r++) begin
            cnt_q[r] <= '0;
         end
         busy_q <= '0;
         err_q  <= 1'b0;
      end else begin
         for (int r = 0; r < 32; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
         busy_q <= busy_d;
         err_q  <= err_q | err_set_d;
      end
   end

   assign o_Issue_1 = issue_c;
   assign o_Stall_1 = stall_c;
   assign o_Busy_32 = busy_q;
   assign o_Err_1   = err_q;

endmodule

// File: tb/tb_grf_scoreboard.sv
module tb_grf_scoreboard;

   localparam int MAXC = 3;

   logic        i_Clk = 1'b0;
   logic        i_Rst;
   logic        i_Valid_1;
   logic [4:0]  i_RS1Addr_5;
   logic        i_RS1Used_1;
   logic [4:0]  i_RS2Addr_5;
   logic        i_RS2Used_1;
   logic [4:0]  i_RDAddr_5;
   logic        i_RDWrite_1;
   logic        i_WBValid_1;
   logic [4:0]  i_WBAddr_5;
   logic        i_Flush_1;
   logic        o_Issue_1;
   logic        o_Stall_1;
   logic [31:0] o_Busy_32;
   logic        o_Err_1;

   int errors = 0;
   int checks = 0;

   logic        obs_issue, obs_stall, obs_err;
   logic [31:0] obs_busy;

   // reference model: pending-write count per register, sticky error
   int          mcnt [32];
   bit          merr;
   bit          m_issue, m_stall;
   logic [31:0] m_busy;

   grf_scoreboard #(.CNT_W(2), .WB_BYPASS(1)) dut (
      .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Valid_1(i_Valid_1),
      .i_RS1Addr_5(i_RS1Addr_5), .i_RS1Used_1(i_RS1Used_1),
      .i_RS2Addr_5(i_RS2Addr_5), .i_RS2Used_1(i_RS2Used_1),
      .i_RDAddr_5(i_RDAddr_5), .i_RDWrite_1(i_RDWrite_1),
      .i_WBValid_1(i_WBValid_1), .i_WBAddr_5(i_WBAddr_5),
      .i_Flush_1(i_Flush_1), .o_Issue_1(o_Issue_1), .o_Stall_1(o_Stall_1),
      .o_Busy_32(o_Busy_32), .o_Err_1(o_Err_1)
   );

   always #5 i_Clk = ~i_Clk;

   function automatic bit retires(input logic [4:0] a);
      return i_WBValid_1 && (i_WBAddr_5 == a) && (a != 5'd0);
   endfunction

   function automatic bit src_blocked(input logic [4:0] a, input bit used);
      if (!used || a == 5'd0 || mcnt[a] == 0) return 0;
      return !(mcnt[a] == 1 && retires(a));
   endfunction

   function automatic void model_eval();
      bit full;
      full = i_RDWrite_1 && i_RDAddr_5 != 5'd0 && mcnt[i_RDAddr_5] == MAXC && !retires(i_RDAddr_5);
      if (i_Rst || !i_Valid_1 || i_Flush_1) begin
         m_stall = 0;
         m_issue = 0;
      end else begin
         m_stall = src_blocked(i_RS1Addr_5, i_RS1Used_1) || src_blocked(i_RS2Addr_5, i_RS2Used_1) || full;
         m_issue = !m_stall;
      end
   endfunction

   function automatic void model_update();
      if (i_Rst) begin
         foreach (mcnt[r]) mcnt[r] = 0;
         merr = 0;
      end else if (i_Flush_1) begin
         foreach (mcnt[r]) mcnt[r] = 0;
      end else begin
         for (int r = 1; r < 32; r++) begin
            bit inc, dec;
            inc = m_issue && i_RDWrite_1 && i_RDAddr_5 == 5'(r);
            dec = i_WBValid_1 && i_WBAddr_5 == 5'(r);
            if (inc && !dec) mcnt[r]++;
            else if (dec && !inc) begin
               if (mcnt[r] == 0) merr = 1;
               else mcnt[r]--;
            end
         end
      end
      m_busy = '0;
      for (int r = 0; r < 32; r++) m_busy[r] = (mcnt[r] != 0);
   endfunction

   task automatic drive(input bit v, input logic [4:0] r1, input bit u1,
                        input logic [4:0] r2, input bit u2,
                        input logic [4:0] rd, input bit w,
                        input bit wbv, input logic [4:0] wba, input bit fl);
      i_Valid_1 = v;   i_RS1Addr_5 = r1; i_RS1Used_1 = u1;
      i_RS2Addr_5 = r2; i_RS2Used_1 = u2; i_RDAddr_5 = rd; i_RDWrite_1 = w;
      i_WBValid_1 = wbv; i_WBAddr_5 = wba; i_Flush_1 = fl;
   endtask

   task automatic idle();
      drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0);
   endtask

   // called at a falling edge with inputs applied; returns at the next falling edge
   task automatic clk_step();
      #1;
      obs_issue = o_Issue_1;
      obs_stall = o_Stall_1;
      model_eval();
      @(posedge i_Clk);
      model_update();
      #1;
      obs_busy = o_Busy_32;
      obs_err  = o_Err_1;
      @(negedge i_Clk);
   endtask

   task automatic test_reset();
      i_Rst = 1'b1;
      drive(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 1, 5'd4, 0);
      clk_step();
      checks++; if (obs_issue !== 1'b0 || obs_stall !== 1'b0) begin errors++;
         $display("FAIL reset_handshake: issue=%0b stall=%0b expected 0/0", obs_issue, obs_stall); end
      checks++; if (obs_busy !== 32'h0 || obs_err !== 1'b0) begin errors++;
         $display("FAIL reset_state: busy=%h err=%0b expected 0/0", obs_busy, obs_err); end
      i_Rst = 1'b0;
      idle();
      clk_step();
   endtask

   task automatic test_basic_issue();
      drive(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 5'd0, 0);   // ADD x3,x1,x2
      clk_step();
      checks++; if (obs_issue !== 1'b1 || obs_stall !== 1'b0) begin errors++;
         $display("FAIL basic_issue: issue=%0b stall=%0b expected 1/0", obs_issue, obs_stall); end
      checks++; if (obs_busy !== 32'h0000_0008) begin errors++;
         $display("FAIL basic_busy: busy=%h expected 00000008", obs_busy); end
      drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 5'd3, 0);
      clk_step();
      checks++; if (obs_busy !== 32'h0 || obs_err !== 1'b0) begin errors++;
         $display("FAIL basic_retire: busy=%h err=%0b expected 0/0", obs_busy, obs_err); end
   endtask

   task automatic test_raw_bypass();
      drive(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 5'd0, 0);
      clk_step();
      checks++; if (obs_issue !== 1'b1 || obs_busy !== 32'h0000_0020) begin errors++;
         $display("FAIL raw_write5: issue=%0b busy=%h expected 1/00000020", obs_issue, obs_busy); end
      for (int k = 0; k < 2; k++) begin
         drive(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 5'd0, 0);
         clk_step();
         checks++; if (obs_stall !== 1'b1 || obs_issue !== 1'b0) begin errors++;
            $display("FAIL raw_stall: stall=%0b issue=%0b expected 1/0", obs_stall, obs_issue); end
      end
      drive(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 1, 5'd5, 0);
      clk_step();
      checks++; if (obs_issue !== 1'b1 || obs_stall !== 1'b0) begin errors++;
         $display("FAIL raw_bypass: issue=%0b stall=%0b expected 1/0", obs_issue, obs_stall); end
      checks++; if (obs_busy !== 32'h0000_0040) begin errors++;
         $display("FAIL raw_after: busy=%h expected 00000040", obs_busy); end
      drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 5'd6, 0);
      clk_step();
   endtask

   task automatic test_waw_full();
      for (int k = 0; k < 3; k++) begin
         drive(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 0, 5'd0, 0);
         clk_step();
         checks++; if (obs_issue !== 1'b1) begin errors++;
            $display("FAIL waw_issue%0d: issue=%0b expected 1", k, obs_issue); end
      end
      drive(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 0, 5'd0, 0);
      clk_step();
      checks++; if (obs_stall !== 1'b1 || obs_issue !== 1'b0) begin errors++;
         $display("FAIL waw_full: stall=%0b issue=%0b expected 1/0", obs_stall, obs_issue); end
      drive(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 1, 5'd7, 0);
      clk_step();
      checks++; if (obs_issue !== 1'b1 || obs_busy !== 32'h0000_0080) begin errors++;
         $display("FAIL waw_wb_same: issue=%0b busy=%h expected 1/00000080", obs_issue, obs_busy); end
      // still three pending: another write must stall
      drive(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 0, 5'd0, 0);
      clk_step();
      checks++; if (obs_stall !== 1'b1) begin errors++;
         $display("FAIL waw_still_full: stall=%0b expected 1", obs_stall); end
      for (int k = 0; k < 3; k++) begin
         drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 5'd7, 0);
         clk_step();
         checks++; if (obs_busy[7] !== (k < 2) || obs_err !== 1'b0) begin errors++;
            $display("FAIL waw_drain%0d: busy7=%0b err=%0b expected %0b/0", k, obs_busy[7], obs_err, k < 2); end
      end
   endtask

   task automatic test_x0();
      for (int k = 0; k < 5; k++) begin
         drive(1, 5'd0, 1, 5'd0, 1, 5'd0, 1, 1, 5'd0, 0);
         clk_step();
         checks++; if (obs_issue !== 1'b1 || obs_stall !== 1'b0) begin errors++;
            $display("FAIL x0_issue%0d: issue=%0b stall=%0b expected 1/0", k, obs_issue, obs_stall); end
         checks++; if (obs_busy !== 32'h0 || obs_err !== 1'b0) begin errors++;
            $display("FAIL x0_state%0d: busy=%h err=%0b expected 0/0", k, obs_busy, obs_err); end
      end
   endtask

   task automatic test_err_flush();
      drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 5'd12, 1);
      clk_step();
      checks++; if (obs_err !== 1'b0) begin errors++;
         $display("FAIL flush_wb_ignored: err=%0b expected 0", obs_err); end
      drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 5'd9, 0);
      clk_step();
      checks++; if (obs_err !== 1'b1 || obs_busy !== 32'h0) begin errors++;
         $display("FAIL err_wb9: err=%0b busy=%h expected 1/00000000", obs_err, obs_busy); end
      drive(1, 5'd0, 0, 5'd0, 0, 5'd4, 1, 0, 5'd0, 0);
      clk_step();
      drive(1, 5'd0, 0, 5'd0, 0, 5'd6, 1, 0, 5'd0, 0);
      clk_step();
      checks++; if (obs_busy !== 32'h0000_0050) begin errors++;
         $display("FAIL flush_pre: busy=%h expected 00000050", obs_busy); end
      drive(1, 5'd0, 0, 5'd0, 0, 5'd8, 1, 1, 5'd4, 1);
      clk_step();
      checks++; if (obs_issue !== 1'b0 || obs_stall !== 1'b0) begin errors++;
         $display("FAIL flush_handshake: issue=%0b stall=%0b expected 0/0", obs_issue, obs_stall); end
      checks++; if (obs_busy !== 32'h0 || obs_err !== 1'b1) begin errors++;
         $display("FAIL flush_post: busy=%h err=%0b expected 0/1", obs_busy, obs_err); end
      drive(1, 5'd4, 1, 5'd6, 1, 5'd0, 0, 0, 5'd0, 0);
      clk_step();
      checks++; if (obs_issue !== 1'b1) begin errors++;
         $display("FAIL flush_cleared: issue=%0b expected 1", obs_issue); end
   endtask

   task automatic test_reset_mid();
      drive(1, 5'd0, 0, 5'd0, 0, 5'd10, 1, 0, 5'd0, 0);
      clk_step();
      i_Rst = 1'b1;
      drive(1, 5'd0, 0, 5'd0, 0, 5'd11, 1, 1, 5'd10, 0);
      clk_step();
      checks++; if (obs_issue !== 1'b0 || obs_stall !== 1'b0) begin errors++;
         $display("FAIL rst_mid_handshake: issue=%0b stall=%0b expected 0/0", obs_issue, obs_stall); end
      checks++; if (obs_busy !== 32'h0 || obs_err !== 1'b0) begin errors++;
         $display("FAIL rst_mid_state: busy=%h err=%0b expected 0/0", obs_busy, obs_err); end
      i_Rst = 1'b0;
      idle();
      clk_step();
   endtask

   task automatic test_random();
      i_Rst = 1'b1;
      idle();
      clk_step();
      i_Rst = 1'b0;
      for (int n = 0; n < 800; n++) begin
         i_Rst = ($urandom_range(0, 199) == 0);
         drive($urandom_range(0, 99) < 85,
               5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 7)), $urandom_range(0, 99) < 70,
               $urandom_range(0, 99) < 40, 5'($urandom_range(0, 7)),
               $urandom_range(0, 99) < 3);
         clk_step();
         checks++; if (obs_issue !== m_issue || obs_stall !== m_stall) begin errors++;
            $display("FAIL rand_handshake[%0d]: issue=%0b stall=%0b expected %0b/%0b", n, obs_issue, obs_stall, m_issue, m_stall); end
         checks++; if (obs_busy !== m_busy || obs_err !== merr) begin errors++;
            $display("FAIL rand_state[%0d]: busy=%h err=%0b expected %h/%0b", n, obs_busy, obs_err, m_busy, merr); end
      end
      i_Rst = 1'b0;
   endtask

   initial begin
      foreach (mcnt[r]) mcnt[r] = 0;
      merr   = 0;
      m_busy = '0;
      i_Rst  = 1'b1;
      idle();
      @(negedge i_Clk);
      test_reset();
      test_basic_issue();
      test_raw_bypass();
      test_waw_full();
      test_x0();
      test_err_flush();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
